memory_pipelined: RTL and testbench
===================================

// Module: memory_pipelined
// PURPOSE
//  Parametrised, byte-addressable synchronous memory for the X-Makina datapath: one write port, READ_PORTS read ports.
//  Each access carries a byte address; write data is steered onto byte lanes by the address offset.
//  Misaligned writes are rejected. Read latency is configurable, with a pipelined valid/error response per port.
//  Selectable read-during-write ordering. Sits between the control unit / MAR-MDR path and the bus.
// PARAMETERS
//  WORD        16     word width in bits; must be a multiple of 8, BPW = WORD/8 (power of 2)
//  BYTES       65536  capacity in bytes; AW = $clog2(BYTES); MEM_WORDS = BYTES/BPW
//  READ_PORTS  2      number of independent read ports (>=1)
//  RD_LAT      1      read latency in cycles, 1..4 (extra output pipeline stages)
//  WR_FIRST    1      1: same-cycle read of the word being written returns the new data; 0: returns the old data
// PORTS
//  clk         in   1                clock; all state updates on posedge
//  rst_n       in   1                asynchronous, active-low reset
//  wr_req      in   1                write request, sampled on posedge
//  wr_addr     in   AW               byte address of the lowest byte written
//  wr_size     in   $clog2(BPW)+1    bytes to write minus 1 (0 = byte, 1 = 2 bytes, ...)
//  wr_data     in   WORD             write data, right-justified (byte 0 = lowest lane written)
//  wr_ack      out  1                one-cycle pulse, 1 cycle after an accepted write
//  wr_err      out  1                one-cycle pulse, 1 cycle after a rejected write
//  rd_req      in   1 x READ_PORTS   read request per port
//  rd_addr     in   AW x READ_PORTS  byte address per port
//  rd_valid    out  1 x READ_PORTS   read response valid, RD_LAT cycles after rd_req
//  rd_data     out  WORD x READ_PORTS  full word containing rd_addr; lane 0 at bits [7:0]
//  rd_off      out  $clog2(BPW) x READ_PORTS  byte offset of rd_addr, delayed to align with rd_data
// BEHAVIOUR
//  - Reset: wr_ack, wr_err, rd_valid = 0; rd_data, rd_off = 0; all read pipeline stages flushed.
//    Memory contents are NOT cleared by reset; the array is zeroed at time 0 only.
//  - Address split: word index = addr >> $clog2(BPW); offset = addr[$clog2(BPW)-1:0].
//  - Write lane enables: be = ((2 << wr_size) - 1) << offset, computed in BPW+BPW bits.
//    wr_data is shifted left by 8*offset.
//  - Write acceptance: a write is accepted if wr_req && offset + wr_size + 1 <= BPW && wr_size < BPW.
//    An accepted write updates only the enabled lanes at the posedge; wr_ack = 1 next cycle.
//  - Write rejection: otherwise the write is rejected. The memory is unchanged and wr_err = 1 next cycle.
//  - Writes are never stalled: one write per cycle, back-to-back allowed.
//  - Read issue: stage 0 captures the word at posedge when rd_req[p].
//    The value then moves through RD_LAT-1 further registers; rd_valid[p] follows the same delay.
//    Fully pipelined: one request per port per cycle. Gaps propagate as rd_valid = 0.
//    rd_data holds its last value when rd_valid = 0.
//  - Read/write collision (same word index in the same cycle):
//    WR_FIRST = 1 -> enabled lanes return the new wr_data bytes and other lanes the old contents.
//    WR_FIRST = 0 -> all lanes return the old contents.
//    A rejected write never forwards.
//  - Multiple read ports may address the same word; all get identical data.
//  - Address wrap: addresses are AW bits, so no wrap beyond BYTES. A write at the last word with overflow is rejected as misaligned.
//  - Reset mid-operation: in-flight reads are dropped (no rd_valid after reset deassert).
//    A write sampled on the same edge reset asserts is not performed.
// TESTING (WORD=16, BYTES=256, READ_PORTS=2)
//  1. Reset, then read 0x10 on port 0 with RD_LAT=1 -> rd_valid[0]=1 next cycle, rd_data=0x0000.
//  2. Write 0xBEEF to addr 0x10 (size 1), then read 0x10 -> wr_ack pulse, rd_data=0xBEEF, rd_off=0.
//  3. Write byte 0x5A to addr 0x11 (size 0) over 0xBEEF; read 0x11 -> rd_data=0x5AEF, rd_off=1.
//  4. Write size 1 to addr 0x21 -> wr_err pulse, no ack; a later read of 0x20 returns the unchanged word.
//  5. Same cycle: write 0x1234 to 0x30 and read 0x30 on both ports.
//     WR_FIRST=1 -> both return 0x1234. WR_FIRST=0 -> both return the prior value.
//  6. RD_LAT=3: reads on cycles 0,1,3 to 0x10,0x12,0x14, assert rst_n=0 at cycle 2
//     -> no rd_valid after reset; a re-issued read arrives 3 cycles later.

Source files
------------

// File: rtl/memory_pipelined.sv
// Byte-addressable synchronous memory: one byte-lane write port, READ_PORTS
// pipelined read ports with configurable latency and read-during-write order.
module memory_pipelined #(
    parameter  int WORD       = 16,
    parameter  int BYTES      = 65536,
    parameter  int READ_PORTS = 2,
    parameter  int RD_LAT     = 1,
    parameter  int WR_FIRST   = 1,
    localparam int BPW        = WORD / 8,
    localparam int AW         = $clog2(BYTES),
    localparam int OW         = $clog2(BPW),
    localparam int OWX        = (OW > 0) ? OW : 1,
    localparam int SW         = OW + 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                wr_req,
    input  logic [AW-1:0]                       wr_addr,
    input  logic [SW-1:0]                       wr_size,
    input  logic [WORD-1:0]                     wr_data,
    output logic                                wr_ack,
    output logic                                wr_err,
    input  logic [READ_PORTS-1:0]               rd_req,
    input  logic [READ_PORTS-1:0][AW-1:0]       rd_addr,
    output logic [READ_PORTS-1:0]               rd_valid,
    output logic [READ_PORTS-1:0][WORD-1:0]     rd_data,
    output logic [READ_PORTS-1:0][OWX-1:0]      rd_off
);

    localparam int MEM_WORDS = BYTES / BPW;
    localparam int IW        = AW - OW;
    localparam int BW2       = 2 * BPW;

    // Contents are only zeroed at time 0; reset leaves them intact.
    logic [WORD-1:0] mem [MEM_WORDS] = '{default: '0};

    logic [AW-1:0]   off_mask;
    logic [AW-1:0]   wr_off_full;
    logic [OWX-1:0]  wr_off;
    logic [IW-1:0]   wr_idx;
    logic [BW2-1:0]  be_wide;
    logic [BPW-1:0]  wr_be;
    logic [WORD-1:0] wr_shift;
    logic            wr_fits;
    logic            wr_ok;

    logic [IW-1:0]                    rd_idx [READ_PORTS];
    logic [READ_PORTS-1:0][OWX-1:0]   rd_o;
    logic [READ_PORTS-1:0][WORD-1:0]  rd_fwd;

    logic [RD_LAT-1:0][READ_PORTS-1:0] vld_q;
    logic [WORD-1:0]                   dat_q [RD_LAT][READ_PORTS];
    logic [OWX-1:0]                    off_q [RD_LAT][READ_PORTS];

    // Write decode: lane enables, lane-aligned data and the alignment check.
    always_comb begin
        off_mask    = AW'(BPW - 1);
        wr_off_full = wr_addr & off_mask;
        wr_off      = wr_off_full[OWX-1:0];
        wr_idx      = IW'(wr_addr >> OW);
        be_wide     = ((BW2'(2) << wr_size) - BW2'(1)) << wr_off;
        wr_be       = be_wide[BPW-1:0];
        wr_shift    = wr_data << {wr_off, 3'b000};
        wr_fits     = (int'(wr_off) + int'(wr_size) + 1 <= BPW) && (int'(wr_size) < BPW);
        wr_ok       = wr_req && wr_fits;
    end

    // Read decode per port, with new-data forwarding on enabled lanes when WR_FIRST.
    always_comb begin
        for (int unsigned p = 0; p < READ_PORTS; p++) begin
            rd_idx[p] = IW'(rd_addr[p] >> OW);
            rd_o[p]   = OWX'(rd_addr[p] & off_mask);
            rd_fwd[p] = mem[rd_idx[p]];
            for (int unsigned b = 0; b < BPW; b++) begin
                if ((WR_FIRST != 0) && wr_ok && (rd_idx[p] == wr_idx) && wr_be[b])
                    rd_fwd[p][8*b +: 8] = wr_shift[8*b +: 8];
            end
        end
    end

    // Byte-lane memory write; a write sampled while reset is asserted is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) begin
            for (int unsigned b = 0; b < BPW; b++) begin
                if (wr_be[b])
                    mem[wr_idx][8*b +: 8] <= wr_shift[8*b +: 8];
            end
        end
    end

    // Write responses and read pipeline; data stages load only on valid so outputs hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
            vld_q  <= '0;
            for (int unsigned s = 0; s < RD_LAT; s++) begin
                for (int unsigned p = 0; p < READ_PORTS; p++) begin
                    dat_q[s][p] <= '0;
                    off_q[s][p] <= '0;
                end
            end
        end else begin
            wr_ack <= wr_ok;
            wr_err <= wr_req && !wr_fits;
            for (int unsigned p = 0; p < READ_PORTS; p++) begin
                vld_q[0][p] <= rd_req[p];
                if (rd_req[p]) begin
                    dat_q[0][p] <= rd_fwd[p];
                    off_q[0][p] <= rd_o[p];
                end
            end
            for (int unsigned s = 1; s < RD_LAT; s++) begin
                for (int unsigned p = 0; p < READ_PORTS; p++) begin
                    vld_q[s][p] <= vld_q[s-1][p];
                    if (vld_q[s-1][p]) begin
                        dat_q[s][p] <= dat_q[s-1][p];
                        off_q[s][p] <= off_q[s-1][p];
                    end
                end
            end
        end
    end

    // Last pipeline stage drives the read response.
    always_comb begin
        rd_valid = vld_q[RD_LAT-1];
        for (int unsigned p = 0; p < READ_PORTS; p++) begin
            rd_data[p] = dat_q[RD_LAT-1][p];
            rd_off[p]  = off_q[RD_LAT-1][p];
        end
    end

endmodule

// File: tb/tb_memory_pipelined.sv
// Testbench: two instances (latency 1 write-first, latency 3 read-first)
// share stimulus; a byte-array model with time-slotted responses checks both.
module tb_memory_pipelined;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wr_req = 1'b0;
    logic [7:0] wr_addr = '0;
    logic [1:0] wr_size = '0;
    logic [15:0] wr_data = '0;
    logic [1:0] rd_req = '0;
    logic [1:0][7:0] rd_addr = '0;

    logic a_wr_ack, a_wr_err, b_wr_ack, b_wr_err;
    logic [1:0] a_rd_valid, b_rd_valid;
    logic [1:0][15:0] a_rd_data, b_rd_data;
    logic [1:0][0:0] a_rd_off, b_rd_off;

    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    memory_pipelined #(.WORD(16), .BYTES(256), .READ_PORTS(2), .RD_LAT(1), .WR_FIRST(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size),
        .wr_data(wr_data), .wr_ack(a_wr_ack), .wr_err(a_wr_err), .rd_req(rd_req),
        .rd_addr(rd_addr), .rd_valid(a_rd_valid), .rd_data(a_rd_data), .rd_off(a_rd_off));

    memory_pipelined #(.WORD(16), .BYTES(256), .READ_PORTS(2), .RD_LAT(3), .WR_FIRST(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size),
        .wr_data(wr_data), .wr_ack(b_wr_ack), .wr_err(b_wr_err), .rd_req(rd_req),
        .rd_addr(rd_addr), .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_off(b_rd_off));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  mbytes [256];
    bit          sv [2][2][8];
    logic [15:0] sd [2][2][8];
    logic        so [2][2][8];
    logic [15:0] held_d [2][2];
    logic        held_o [2][2];
    bit          exp_v [2][2];
    bit          exp_ack, exp_err;
    int          ncyc = 0;

    initial begin
        for (int i = 0; i < 256; i++) mbytes[i] = 8'h00;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                held_d[d][p] = '0; held_o[d][p] = 1'b0; exp_v[d][p] = 1'b0;
                for (int k = 0; k < 8; k++) sv[d][p][k] = 1'b0;
            end
        exp_ack = 1'b0; exp_err = 1'b0;
    end

    always @(posedge clk) begin
        int wa, ws, lat, ba, slot;
        bit accept;
        logic [15:0] word;
        logic [15:0] wd;
        if (!rst_n) begin
            for (int d = 0; d < 2; d++)
                for (int p = 0; p < 2; p++) begin
                    held_d[d][p] = '0; held_o[d][p] = 1'b0; exp_v[d][p] = 1'b0;
                    for (int k = 0; k < 8; k++) sv[d][p][k] = 1'b0;
                end
            exp_ack = 1'b0; exp_err = 1'b0;
        end else begin
            wa = int'(wr_addr); ws = int'(wr_size); wd = wr_data;
            accept = wr_req && (ws < 2) && ((wa % 2) + ws + 1 <= 2);
            for (int d = 0; d < 2; d++) begin
                lat = (d == 0) ? 1 : 3;
                for (int p = 0; p < 2; p++) begin
                    if (rd_req[p]) begin
                        for (int b = 0; b < 2; b++) begin
                            ba = (int'(rd_addr[p]) / 2) * 2 + b;
                            word[8*b +: 8] = mbytes[ba];
                            if (d == 0 && accept && ba >= wa && ba <= wa + ws)
                                word[8*b +: 8] = wd[8*(ba - wa) +: 8];
                        end
                        slot = (ncyc + lat - 1) % 8;
                        sv[d][p][slot] = 1'b1;
                        sd[d][p][slot] = word;
                        so[d][p][slot] = rd_addr[p][0];
                    end
                end
            end
            for (int d = 0; d < 2; d++)
                for (int p = 0; p < 2; p++) begin
                    slot = ncyc % 8;
                    exp_v[d][p] = sv[d][p][slot];
                    if (sv[d][p][slot]) begin
                        held_d[d][p] = sd[d][p][slot];
                        held_o[d][p] = so[d][p][slot];
                    end
                    sv[d][p][slot] = 1'b0;
                end
            exp_ack = accept;
            exp_err = wr_req && !accept;
            if (accept)
                for (int i = 0; i <= ws; i++) mbytes[wa + i] = wd[8*i +: 8];
        end
        ncyc++;
    end

    // Per-cycle comparison of both instances against the model.
    always @(posedge clk) begin
        #2;
        chk("a_wr_ack", a_wr_ack, exp_ack);
        chk("a_wr_err", a_wr_err, exp_err);
        chk("b_wr_ack", b_wr_ack, exp_ack);
        chk("b_wr_err", b_wr_err, exp_err);
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("a_rd_valid%0d", p), a_rd_valid[p], exp_v[0][p]);
            chk($sformatf("a_rd_data%0d", p), a_rd_data[p], held_d[0][p]);
            chk($sformatf("a_rd_off%0d", p), a_rd_off[p], held_o[0][p]);
            chk($sformatf("b_rd_valid%0d", p), b_rd_valid[p], exp_v[1][p]);
            chk($sformatf("b_rd_data%0d", p), b_rd_data[p], held_d[1][p]);
            chk($sformatf("b_rd_off%0d", p), b_rd_off[p], held_o[1][p]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [1:0] s, input logic [15:0] d);
        wr_req = 1'b1; wr_addr = a; wr_size = s; wr_data = d;
    endtask

    task automatic rd(input int p, input logic [7:0] a);
        rd_req[p] = 1'b1; rd_addr[p] = a;
    endtask

    task automatic idle();
        wr_req = 1'b0; rd_req = '0;
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // 1: read of never-written word
        rd(0, 8'h10); tick(); idle();
        chk("t1_valid", a_rd_valid[0], 1'b1);
        chk("t1_data", a_rd_data[0], 16'h0000);

        // 2: halfword write then read
        wr(8'h10, 2'd1, 16'hBEEF); tick(); idle();
        chk("t2_ack", a_wr_ack, 1'b1);
        chk("t2_err", a_wr_err, 1'b0);
        rd(0, 8'h10); tick(); idle();
        chk("t2_data", a_rd_data[0], 16'hBEEF);
        chk("t2_off", a_rd_off[0], 1'b0);

        // 3: byte write into upper lane
        wr(8'h11, 2'd0, 16'h005A); tick(); idle();
        rd(1, 8'h11); tick(); idle();
        chk("t3_data", a_rd_data[1], 16'h5AEF);
        chk("t3_off", a_rd_off[1], 1'b1);

        // 4: misaligned halfword rejected
        wr(8'h21, 2'd1, 16'hDEAD); tick(); idle();
        chk("t4_err", a_wr_err, 1'b1);
        chk("t4_ack", a_wr_ack, 1'b0);
        rd(0, 8'h20); tick(); idle();
        chk("t4_data", a_rd_data[0], 16'h0000);

        // boundaries: last-word overflow, oversize, then legal last byte
        wr(8'hFF, 2'd1, 16'h1111); tick();
        chk("bnd_ff_err", a_wr_err, 1'b1);
        wr(8'h40, 2'd2, 16'h2222); tick();
        wr(8'h41, 2'd3, 16'h3333); tick();
        wr(8'hFF, 2'd0, 16'h0077); tick(); idle();
        chk("bnd_last_ack", a_wr_ack, 1'b1);
        rd(0, 8'hFE); rd(1, 8'h40); tick(); idle();
        chk("bnd_fe_data", a_rd_data[0], 16'h7700);
        chk("bnd_40_data", a_rd_data[1], 16'h0000);

        // 5: read-during-write on both ports
        wr(8'h30, 2'd1, 16'hA5C3); tick();
        wr(8'h30, 2'd1, 16'h1234); rd(0, 8'h30); rd(1, 8'h30); tick(); idle();
        chk("t5_a0", a_rd_data[0], 16'h1234);
        chk("t5_a1", a_rd_data[1], 16'h1234);
        tick(); tick();
        chk("t5_bv", b_rd_valid, 2'b11);
        chk("t5_b0", b_rd_data[0], 16'hA5C3);
        chk("t5_b1", b_rd_data[1], 16'hA5C3);

        // partial-lane collision: only the written lane forwards
        wr(8'h31, 2'd0, 16'h0099); rd(0, 8'h30); tick(); idle();
        chk("pl_a0", a_rd_data[0], 16'h9934);
        rd(1, 8'h31); tick(); rd(0, 8'h32); tick(); idle();
        repeat (3) tick();

        // 6: reset with reads in flight
        rd(0, 8'h10); tick();
        rd(0, 8'h12); tick();
        idle(); rst_n = 1'b0; tick();
        chk("t6_rst_bv", b_rd_valid, 2'b00);
        rst_n = 1'b1; rd(0, 8'h14); tick(); idle();
        chk("t6_bv_1", b_rd_valid[0], 1'b0);
        tick();
        chk("t6_bv_2", b_rd_valid[0], 1'b0);
        tick();
        chk("t6_bv_3", b_rd_valid[0], 1'b1);
        chk("t6_boff", b_rd_off[0], 1'b0);
        chk("t6_bdata", b_rd_data[0], 16'h0000);

        // contents survive reset
        rd(0, 8'h10); tick(); idle();
        chk("persist", a_rd_data[0], 16'h5AEF);
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
